// File: rtl/adc_spi_responder.sv
// SPI responder model of a register-programmed ADC: lock/unlock, 32x8 register file,
// one-frame response latency and a free-running data-ready generator.
module adc_spi_responder #(
  parameter int unsigned WORD_BITS       = 16,
  parameter int unsigned WORDS_PER_FRAME = 2,
  parameter int unsigned DRDY_PERIOD     = 1000
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_CS,
  input  logic                 SPI_MOSI,
  output logic                 SPI_MISO,
  input  logic                 SPI_RESET,
  output logic                 DRDY_n,
  output logic                 cmd_valid,
  output logic [WORD_BITS-1:0] cmd_word,
  output logic                 frame_error,
  output logic                 unlocked
);

  localparam int unsigned FRAME_BITS = WORD_BITS * WORDS_PER_FRAME;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned DRDY_W     = (DRDY_PERIOD > 1) ? $clog2(DRDY_PERIOD) : 1;

  // Synchronizers are deliberately unreset so a device reset cannot fake a CS edge.
  logic [1:0] sclk_sync, cs_sync, mosi_sync, rst_sync;
  logic       sclk_prev, cs_prev;

  always_ff @(posedge system_clock) begin
    sclk_sync <= {sclk_sync[0], SPI_SCLK};
    cs_sync   <= {cs_sync[0], SPI_CS};
    mosi_sync <= {mosi_sync[0], SPI_MOSI};
    rst_sync  <= {rst_sync[0], SPI_RESET};
    sclk_prev <= sclk_sync[1];
    cs_prev   <= cs_sync[1];
  end

  logic sclk_s, cs_s, mosi_s, dev_rst;
  logic in_frame_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign dev_rst   = reset | ~rst_sync[1];
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign sclk_rise = sclk_s & ~sclk_prev & ~cs_s & in_frame_q;
  assign sclk_fall = ~sclk_s & sclk_prev & ~cs_s & in_frame_q;

  logic [CNT_W-1:0]      bit_cnt_q;
  logic [WORD_BITS-2:0]  rx_q;
  logic [WORD_BITS-1:0]  cmd_q, resp_q;
  logic [FRAME_BITS-1:0] tx_q, tx_load;
  logic [15:0]           data_q;
  logic [7:0]            regs_q [32];
  logic                  miso_q, cmd_valid_q, frame_error_q, unlocked_q;
  logic [WORD_BITS-1:0]  cmd_word_q;
  logic                  frame_full, frame_sat;

  assign frame_full = (bit_cnt_q == CNT_W'(FRAME_BITS));
  assign frame_sat  = (bit_cnt_q >= CNT_W'(FRAME_BITS));
  assign tx_load    = FRAME_BITS'({resp_q, data_q}) << (FRAME_BITS - WORD_BITS - 16);

  // Command decode, evaluated against the command captured in the frame now ending.
  logic [4:0]           addr;
  logic [7:0]           wdata, rd_data;
  logic [WORD_BITS-1:0] resp_exec;
  logic                 unlock_next, wr_en;

  assign addr    = cmd_q[12:8];
  assign wdata   = cmd_q[7:0];
  assign rd_data = (addr == 5'd0) ? 8'h04 : regs_q[addr];

  always_comb begin
    resp_exec   = WORD_BITS'(16'h2201);
    unlock_next = unlocked_q;
    wr_en       = 1'b0;
    if (cmd_q == WORD_BITS'(16'h0000)) begin
      resp_exec = WORD_BITS'(16'h2200);
    end else if (cmd_q == WORD_BITS'(16'h0655)) begin
      unlock_next = 1'b1;
      resp_exec   = WORD_BITS'(16'h0655);
    end else if (cmd_q == WORD_BITS'(16'h0555)) begin
      unlock_next = 1'b0;
      resp_exec   = WORD_BITS'(16'h0555);
    end else if (cmd_q[15:13] == 3'b001) begin
      resp_exec = WORD_BITS'({3'b001, addr, rd_data});
    end else if (cmd_q[15:13] == 3'b010 && unlocked_q && addr != 5'd0) begin
      wr_en     = 1'b1;
      resp_exec = WORD_BITS'({3'b010, addr, wdata});
    end
  end

  always_ff @(posedge system_clock) begin
    if (dev_rst) begin
      in_frame_q    <= 1'b0;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      cmd_q         <= '0;
      tx_q          <= '0;
      resp_q        <= WORD_BITS'(16'hFF04);
      miso_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      cmd_word_q    <= '0;
      unlocked_q    <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
    end else begin
      cmd_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      if (cs_fall) begin
        in_frame_q <= 1'b1;
        bit_cnt_q  <= '0;
        tx_q       <= tx_load;
      end else if (cs_rise) begin
        in_frame_q <= 1'b0;
        if (in_frame_q && frame_full) begin
          cmd_valid_q <= 1'b1;
          cmd_word_q  <= cmd_q;
          resp_q      <= resp_exec;
          unlocked_q  <= unlock_next;
          if (wr_en) regs_q[addr] <= wdata;
        end else if (in_frame_q && bit_cnt_q != '0) begin
          frame_error_q <= 1'b1;
        end
      end
      if (cs_s) begin
        miso_q <= 1'b0;
      end else if (sclk_rise && !frame_sat) begin
        miso_q <= tx_q[FRAME_BITS-1];
        tx_q   <= tx_q << 1;
      end
      if (sclk_fall && !frame_sat) begin
        rx_q      <= {rx_q[WORD_BITS-3:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) cmd_q <= {rx_q, mosi_s};
      end
    end
  end

  logic [DRDY_W-1:0] drdy_cnt_q;
  logic              drdy_n_q;

  always_ff @(posedge system_clock) begin
    if (dev_rst) begin
      drdy_cnt_q <= '0;
      drdy_n_q   <= 1'b1;
      data_q     <= '0;
    end else if (!unlocked_q) begin
      drdy_cnt_q <= '0;
      drdy_n_q   <= 1'b1;
    end else begin
      if (cs_fall) drdy_n_q <= 1'b1;
      if (drdy_cnt_q == DRDY_W'(DRDY_PERIOD - 1)) begin
        drdy_cnt_q <= '0;
        drdy_n_q   <= 1'b0;
        data_q     <= data_q + 16'd1;
      end else begin
        drdy_cnt_q <= drdy_cnt_q + 1'b1;
      end
    end
  end

  assign SPI_MISO    = miso_q;
  assign DRDY_n      = drdy_n_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_word    = cmd_word_q;
  assign frame_error = frame_error_q;
  assign unlocked    = unlocked_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: SPI master model, hand-computed responses.
module tb_adc_spi_responder;

  logic        system_clock;
  logic        reset;
  logic        SPI_SCLK, SPI_CS, SPI_MOSI, SPI_RESET;
  logic        SPI_MISO, DRDY_n, cmd_valid, frame_error, unlocked;
  logic [15:0] cmd_word;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int cv_cnt  = 0;
  int fe_cnt  = 0;
  int cs_rise_cyc = 0;

  adc_spi_responder #(
    .WORD_BITS      (16),
    .WORDS_PER_FRAME(2),
    .DRDY_PERIOD    (1000)
  ) dut (
    .system_clock(system_clock),
    .reset       (reset),
    .SPI_SCLK    (SPI_SCLK),
    .SPI_CS      (SPI_CS),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_MISO    (SPI_MISO),
    .SPI_RESET   (SPI_RESET),
    .DRDY_n      (DRDY_n),
    .cmd_valid   (cmd_valid),
    .cmd_word    (cmd_word),
    .frame_error (frame_error),
    .unlocked    (unlocked)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  always @(posedge system_clock) begin
    cyc <= cyc + 1;
    if (cmd_valid) cv_cnt <= cv_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  // Master drives MOSI on SCLK rise and samples MISO late in the high phase (CPHA=1).
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int reset_at,
                           output logic [31:0] rd);
    logic [31:0] mo;
    mo = {cmd, 16'h0000};
    rd = '0;
    SPI_CS = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_at) begin
        reset = 1'b1;
        wait_clk(4);
        reset = 1'b0;
      end
      SPI_SCLK = 1'b1;
      SPI_MOSI = (i < 32) ? mo[31-i] : 1'b0;
      wait_clk(8);
      if (i < 32) rd[31-i] = SPI_MISO;
      SPI_SCLK = 1'b0;
      wait_clk(8);
    end
    wait_clk(8);
    SPI_CS = 1'b1;
    cs_rise_cyc = cyc;
    wait_clk(16);
  endtask

  task automatic frame(input logic [15:0] cmd, output logic [31:0] rd);
    spi_frame(cmd, 32, -1, rd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int cv0, fe0, t0, lat;

    reset = 1'b1; SPI_SCLK = 1'b0; SPI_CS = 1'b1; SPI_MOSI = 1'b0; SPI_RESET = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    check("rst_drdy", 32'(DRDY_n), 1);
    check("rst_miso", 32'(SPI_MISO), 0);
    check("rst_unlocked", 32'(unlocked), 0);
    check("rst_cmd_word", 32'(cmd_word), 0);

    SPI_RESET = 1'b0;
    wait_clk(20);
    SPI_RESET = 1'b1;
    wait_clk(4);

    cv0 = cv_cnt; fe0 = fe_cnt;
    frame(16'h0655, rd);
    check("unlock_w0", 32'(rd[31:16]), 32'hFF04);
    check("unlock_w1", 32'(rd[15:0]), 32'h0000);
    check("unlock_cv", 32'(cv_cnt - cv0), 1);
    check("unlock_fe", 32'(fe_cnt - fe0), 0);
    check("unlock_state", 32'(unlocked), 1);
    check("unlock_cmd_word", 32'(cmd_word), 32'h0655);
    frame(16'h0000, rd);
    check("null_after_unlock", 32'(rd[31:16]), 32'h0655);

    frame(16'h4A5C, rd);
    check("wreg_resp_prev", 32'(rd[31:16]), 32'h2200);
    frame(16'h2A00, rd);
    check("wreg_resp", 32'(rd[31:16]), 32'h4A5C);
    frame(16'h0000, rd);
    check("rreg_resp", 32'(rd[31:16]), 32'h2A5C);

    frame(16'h2000, rd);
    frame(16'h4011, rd);
    check("rreg0_resp", 32'(rd[31:16]), 32'h2004);
    frame(16'hE000, rd);
    check("wreg0_ignored", 32'(rd[31:16]), 32'h2201);
    frame(16'h0555, rd);
    check("bad_opcode", 32'(rd[31:16]), 32'h2201);
    check("lock_state", 32'(unlocked), 0);
    frame(16'h0000, rd);
    check("lock_resp", 32'(rd[31:16]), 32'h0555);

    cv0 = cv_cnt; fe0 = fe_cnt;
    spi_frame(16'h0655, 10, -1, rd);
    check("short_fe", 32'(fe_cnt - fe0), 1);
    check("short_cv", 32'(cv_cnt - cv0), 0);
    check("short_unlocked", 32'(unlocked), 0);
    frame(16'h0000, rd);
    check("short_resp_kept", 32'(rd[31:16]), 32'h2200);

    cv0 = cv_cnt; fe0 = fe_cnt;
    spi_frame(16'h2A00, 34, -1, rd);
    check("sat_cv", 32'(cv_cnt - cv0), 1);
    check("sat_fe", 32'(fe_cnt - fe0), 0);
    frame(16'h0000, rd);
    check("sat_rreg_resp", 32'(rd[31:16]), 32'h2A5C);

    reset = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(4);
    frame(16'h4A5C, rd);
    check("locked_wreg_prev", 32'(rd[31:16]), 32'hFF04);
    frame(16'h2A00, rd);
    check("locked_wreg_resp", 32'(rd[31:16]), 32'h2201);
    frame(16'h0000, rd);
    check("locked_rreg_resp", 32'(rd[31:16]), 32'h2A00);

    frame(16'h0655, rd);
    t0 = cs_rise_cyc;
    check("drdy_idle_high", 32'(DRDY_n), 1);
    while (DRDY_n && cyc < t0 + 1200) wait_clk(1);
    lat = cyc - t0;
    check("drdy_first_fall", 32'(lat >= 998 && lat <= 1008), 1);
    while (cyc < t0 + 2500) wait_clk(1);
    check("drdy_held_2500", 32'(DRDY_n), 0);
    while (cyc < t0 + 3100) wait_clk(1);
    check("drdy_held_3100", 32'(DRDY_n), 0);
    frame(16'h0000, rd);
    check("drdy_data_word", 32'(rd[15:0]), 32'h0003);
    check("drdy_resp", 32'(rd[31:16]), 32'h0655);
    check("drdy_cleared", 32'(DRDY_n), 1);

    fe0 = fe_cnt;
    spi_frame(16'h0000, 32, 17, rd);
    check("midreset_fe", 32'(fe_cnt - fe0), 0);
    check("midreset_unlocked", 32'(unlocked), 0);
    frame(16'h0000, rd);
    check("midreset_w0", 32'(rd[31:16]), 32'hFF04);
    check("midreset_w1", 32'(rd[15:0]), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter WORD_BITS, default 16: bits per SPI word.
REQ-002 SHALL have parameter WORDS_PER_FRAME, default 2: words per chip-select frame (32 SCLK total).
REQ-003 SHALL have parameter DRDY_PERIOD, default 1000: system_clock cycles between data-ready events.
REQ-004 SHALL have port system_clock, input, 1: single clock for all logic, including synchronizers.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port SPI_SCLK, input, 1: serial clock from master; CPOL=0.
REQ-007 SHALL have port SPI_CS, input, 1: active-low chip select.
REQ-008 SHALL have port SPI_MOSI, input, 1: master-to-responder data, MSB first.
REQ-009 SHALL have port SPI_MISO, output, 1: responder-to-master data, MSB first.
REQ-010 SHALL have port SPI_RESET, input, 1: active-low device reset pin driven by master.
REQ-011 SHALL have port DRDY_n, output, 1: active-low data-ready.
REQ-012 SHALL have port cmd_valid, output, 1: one-cycle pulse per executed command.
REQ-013 SHALL have port cmd_word, output, WORD_BITS: last executed command word.
REQ-014 SHALL have port frame_error, output, 1: one-cycle pulse on an aborted frame.
REQ-015 SHALL have port unlocked, output, 1: high when the device is unlocked.

Function
REQ-016 SHALL pass SPI_SCLK, SPI_CS, SPI_MOSI and SPI_RESET through 2-FF synchronizers; all edge detection SHALL use synchronized values; SCLK SHALL be at most system_clock/8.
REQ-017 SHALL sample MOSI on each synchronized SCLK falling edge while CS is low, shifting into rx register and incrementing bit_cnt (6 bits).
REQ-018 SHALL, on each synchronized SCLK rising edge while CS is low, drive SPI_MISO from tx register MSB and then shift tx left (CPHA=1).
REQ-019 SHALL load tx with {resp_word, data_word} on the synchronized CS falling edge, clearing bit_cnt; SPI_MISO SHALL be 0 while CS is high.
REQ-020 SHALL capture the first received word as the command when bit_cnt reaches WORD_BITS.
REQ-021 SHALL, on CS rising edge with bit_cnt == WORD_BITS*WORDS_PER_FRAME, execute the command, pulse cmd_valid, update cmd_word and compute resp_word for the next frame (one-frame response latency).
REQ-022 SHALL, on CS rising edge with bit_cnt neither 0 nor full, pulse frame_error, discard the command and leave resp_word unchanged; CS rising with bit_cnt 0 SHALL have no effect.
REQ-023 SHALL ignore SCLK edges beyond the full count in a frame (bit_cnt saturates).
REQ-024 SHALL decode 0x0000 NULL as resp 0x2200.
REQ-025 SHALL decode 0x0655 UNLOCK as unlocked<=1, resp 0x0655.
REQ-026 SHALL decode 0x0555 LOCK as unlocked<=0, resp 0x0555.
REQ-027 SHALL decode 001a_aaaa_xxxx_xxxx RREG as resp {3'b001, a, reg[a]}; RREG SHALL be accepted in both lock states.
REQ-028 SHALL decode 010a_aaaa_dddd_dddd WREG, when unlocked and a != 0, as reg[a]<=d and resp {3'b010, a, d}.
REQ-029 SHALL treat any other opcode, a WREG while locked, or a WREG to a == 0 as ignored, with resp 0x2201.
REQ-030 SHALL implement the register file as 32 x 8 bits; reg[0] reads 0x04 and is read-only; all others reset to 0x00.
REQ-031 SHALL, while unlocked, assert DRDY_n low each time the cycle counter reaches DRDY_PERIOD-1, then wrap the counter to 0 and increment data_word (16 bits, 0xFFFF wraps to 0x0000).
REQ-032 SHALL return DRDY_n high on the synchronized CS falling edge.
REQ-033 SHALL hold DRDY_n low if a period elapses while DRDY_n is already low, still incrementing data_word.
REQ-034 SHALL, while locked, hold the DRDY counter at 0 and DRDY_n high.

Reset
REQ-035 SHALL, on reset high or synchronized SPI_RESET low, hold all state: unlocked=0, resp_word=0xFF04 (READY), data_word=0, DRDY_n=1, SPI_MISO=0, cmd_valid=0, frame_error=0, cmd_word=0, registers at defaults, bit_cnt=0.
REQ-036 SHALL abort any frame in progress when reset is applied mid-frame, without a frame_error pulse; the next full frame SHALL return 0xFF04.

Verification
REQ-037 SHALL verify: SPI_RESET low 20 cycles, then a frame with 0x0655 -> MISO word0 0xFF04; next NULL frame returns 0x0655, unlocked=1, cmd_valid 1 pulse.
REQ-038 SHALL verify: unlocked, WREG 0x4A5C then RREG 0x2A00 -> RREG frame returns 0x4A5C, following NULL frame returns 0x2A5C.
REQ-039 SHALL verify: locked, WREG 0x4A5C -> next response 0x2201, RREG 0x2A00 then returns 0x2A00.
REQ-040 SHALL verify: CS raised after 10 SCLKs -> frame_error pulse, cmd_valid stays 0, next frame resp unchanged.
REQ-041 SHALL verify: unlocked, DRDY_PERIOD=1000, no frames for 3000 cycles -> DRDY_n falls at cycle 999 and stays low; next frame word1 = 3; DRDY_n rises at CS fall.
REQ-042 SHALL verify: reset asserted at bit 17 of a frame -> no frame_error, unlocked=0, next full frame word0 0xFF04, word1 0x0000.
